// File: rtl/opto_ram_pkg.sv
// opto_ram_pkg: shared widths, clear-sweep states and read requester tags
// for the optical-encoder lookup RAM controller.
package opto_ram_pkg;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} clrState_t;
    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;
endpackage

// File: rtl/opto_rd_arb.sv
// opto_rd_arb: fixed-priority read arbiter (A over B) with a starvation guard for B,
// write-collision stall and a 1-bit tag steering the returned RAM word.
module opto_rd_arb
    import opto_ram_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              rdaReq,
    input  logic [ADDR_W-1:0] rdaAddr,
    input  logic              rdbReq,
    input  logic [ADDR_W-1:0] rdbAddr,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] ramQ,
    output logic              rdaAck,
    output logic              rdbAck,
    output logic              rdaVld,
    output logic              rdbVld,
    output logic [DATA_W-1:0] rdaData,
    output logic [DATA_W-1:0] rdbData,
    output logic [ADDR_W-1:0] ramRdAddr,
    output logic              ramRdCe
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]     starve;
    logic              pickB;
    logic              grant;
    logic              tag;
    logic              pend;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] holdA;
    logic [DATA_W-1:0] holdB;

    // A same-cycle write to the winning address stalls the read so it sees the new data.
    always_comb begin
        pickB     = rdbReq && (!rdaReq || starve >= SW'(STARVE_MAX));
        winAddr   = pickB ? rdbAddr : rdaAddr;
        grant     = rstN && (rdaReq || rdbReq) && !(wrEn && winAddr == wrAddr);
        rdaAck    = grant && !pickB;
        rdbAck    = grant && pickB;
        ramRdCe   = grant;
        ramRdAddr = grant ? winAddr : '0;
        rdaVld    = pend && tag == TAG_A;
        rdbVld    = pend && tag == TAG_B;
        rdaData   = rdaVld ? ramQ : holdA;
        rdbData   = rdbVld ? ramQ : holdB;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            starve <= '0;
            tag    <= TAG_A;
            pend   <= 1'b0;
            holdA  <= '0;
            holdB  <= '0;
        end else begin
            pend   <= grant;
            tag    <= grant ? (pickB ? TAG_B : TAG_A) : tag;
            holdA  <= rdaVld ? ramQ : holdA;
            holdB  <= rdbVld ? ramQ : holdB;
            starve <= (!rdbReq || rdbAck) ? '0 : pickB ? starve : starve + 1'b1;
        end
    end
endmodule

// File: rtl/opto_ram_ctrl.sv
// opto_ram_ctrl: sequencer/arbiter for the 256x8 encoder lookup RAM; clear sweep
// and host writes share the write port, two requesters share the read port.
module opto_ram_ctrl
    import opto_ram_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rda_req,
    input  logic [ADDR_W-1:0] i_rda_addr,
    output logic              o_rda_ack,
    output logic              o_rda_vld,
    output logic [DATA_W-1:0] o_rda_data,
    input  logic              i_rdb_req,
    input  logic [ADDR_W-1:0] i_rdb_addr,
    output logic              o_rdb_ack,
    output logic              o_rdb_vld,
    output logic [DATA_W-1:0] o_rdb_data,
    output logic [ADDR_W-1:0] o_ram_wr_addr,
    output logic [DATA_W-1:0] o_ram_wr_data,
    output logic              o_ram_we,
    output logic              o_ram_wr_ce,
    output logic [ADDR_W-1:0] o_ram_rd_addr,
    output logic              o_ram_rd_ce,
    input  logic [DATA_W-1:0] i_ram_q
);
    clrState_t         state;
    clrState_t         stateNext;
    logic [ADDR_W-1:0] clrCnt;
    logic [ADDR_W:0]   clrInc;
    logic              sweeping;
    logic              hostGnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            clrCnt <= '0;
        end else begin
            state  <= stateNext;
            clrCnt <= state == SWEEP ? clrInc[ADDR_W-1:0] : '0;
        end
    end

    // The host write waits out the whole sweep, including a request landing with the clear.
    always_comb begin
        stateNext = IDLE;
        clrInc    = {1'b0, clrCnt} + 1'b1;
        case (state)
            IDLE:    stateNext = i_clr_req ? SWEEP : IDLE;
            SWEEP:   stateNext = clrInc[ADDR_W] ? DONE : SWEEP;
            default: stateNext = IDLE;
        endcase
        sweeping      = state == SWEEP;
        hostGnt       = i_rst_n && i_wr_req && state == IDLE && !i_clr_req;
        o_clr_busy    = sweeping;
        o_clr_done    = state == DONE;
        o_wr_ack      = hostGnt;
        o_ram_we      = sweeping || hostGnt;
        o_ram_wr_ce   = sweeping || hostGnt;
        o_ram_wr_addr = sweeping ? clrCnt : hostGnt ? i_wr_addr : '0;
        o_ram_wr_data = hostGnt && !sweeping ? i_wr_data : '0;
    end

    opto_rd_arb #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_rdArb (
        .clk      (i_clk),
        .rstN     (i_rst_n),
        .rdaReq   (i_rda_req),
        .rdaAddr  (i_rda_addr),
        .rdbReq   (i_rdb_req),
        .rdbAddr  (i_rdb_addr),
        .wrEn     (o_ram_we),
        .wrAddr   (o_ram_wr_addr),
        .ramQ     (i_ram_q),
        .rdaAck   (o_rda_ack),
        .rdbAck   (o_rdb_ack),
        .rdaVld   (o_rda_vld),
        .rdbVld   (o_rdb_vld),
        .rdaData  (o_rda_data),
        .rdbData  (o_rdb_data),
        .ramRdAddr(o_ram_rd_addr),
        .ramRdCe  (o_ram_rd_ce)
    );
endmodule

// File: tb/tb_opto_ram_ctrl.sv
// tb_opto_ram_ctrl: directed plan scenarios plus random traffic, checked every cycle
// against a cycle-level reference model of the controller and an attached RAM.
module tb_opto_ram_ctrl;
    localparam int STARVE_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clrReq, wrReq, aReq, bReq, initRam;
    logic [7:0] wrAddr, wrData, aAddr, bAddr;
    logic       o_clr_busy, o_clr_done, o_wr_ack;
    logic       o_rda_ack, o_rda_vld, o_rdb_ack, o_rdb_vld;
    logic [7:0] o_rda_data, o_rdb_data;
    logic [7:0] o_ram_wr_addr, o_ram_wr_data, o_ram_rd_addr;
    logic       o_ram_we, o_ram_wr_ce, o_ram_rd_ce;
    logic [7:0] ramQ = 8'h00;
    logic [7:0] ram [256];

    int numCompared = 0;
    int numMismatched = 0;

    // reference model state
    logic [7:0] mem [256];
    int         mSweep, mStarve;
    logic       mPendA, mPendB;
    logic [7:0] mDataA, mDataB, holdA, holdB;
    logic       eBusy, eDone, eWrAck, eWe, eAckA, eAckB, eRdCe, eVldA, eVldB;
    logic [7:0] eWa, eWd, eRa, eDA, eDB;
    logic       sBusy, sDone, sWrAck, sAckA, sAckB, sVldA, sVldB;
    logic [7:0] sDA, sDB;

    always #5 clk = ~clk;

    opto_ram_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_clr_req(clrReq), .o_clr_busy(o_clr_busy), .o_clr_done(o_clr_done),
        .i_wr_req(wrReq), .i_wr_addr(wrAddr), .i_wr_data(wrData), .o_wr_ack(o_wr_ack),
        .i_rda_req(aReq), .i_rda_addr(aAddr), .o_rda_ack(o_rda_ack),
        .o_rda_vld(o_rda_vld), .o_rda_data(o_rda_data),
        .i_rdb_req(bReq), .i_rdb_addr(bAddr), .o_rdb_ack(o_rdb_ack),
        .o_rdb_vld(o_rdb_vld), .o_rdb_data(o_rdb_data),
        .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_data(o_ram_wr_data),
        .o_ram_we(o_ram_we), .o_ram_wr_ce(o_ram_wr_ce),
        .o_ram_rd_addr(o_ram_rd_addr), .o_ram_rd_ce(o_ram_rd_ce), .i_ram_q(ramQ)
    );

    always @(posedge clk) begin
        if (initRam) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
        end else begin
            if (o_ram_we && o_ram_wr_ce) ram[o_ram_wr_addr] <= o_ram_wr_data;
            if (o_ram_rd_ce) ramQ <= ram[o_ram_rd_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] allOut();
        return 64'({o_clr_busy, o_clr_done, o_wr_ack, o_rda_ack, o_rdb_ack, o_rda_vld, o_rdb_vld,
                    o_rda_data, o_rdb_data, o_ram_wr_addr, o_ram_wr_data, o_ram_we, o_ram_wr_ce,
                    o_ram_rd_addr, o_ram_rd_ce});
    endfunction

    // Entered just after a rising edge with inputs driven; predicts, compares at the falling
    // edge, advances the model, and returns just after the next rising edge.
    task automatic step();
        logic sweeping, doneCyc, idle, candB, coll;
        logic [7:0] ca;
        sweeping = mSweep >= 0 && mSweep < 256;
        doneCyc  = mSweep == 256;
        idle     = mSweep < 0;
        eBusy    = sweeping;
        eDone    = doneCyc;
        eWrAck   = wrReq && idle && !clrReq;
        eWe      = sweeping || eWrAck;
        eWa      = sweeping ? 8'(mSweep) : eWrAck ? wrAddr : 8'h00;
        eWd      = (!sweeping && eWrAck) ? wrData : 8'h00;
        candB    = bReq && (!aReq || mStarve >= STARVE_MAX);
        ca       = candB ? bAddr : aAddr;
        coll     = eWe && ca == eWa;
        eAckA    = aReq && !candB && !coll;
        eAckB    = candB && !coll;
        eRdCe    = eAckA || eAckB;
        eRa      = eRdCe ? ca : 8'h00;
        eVldA    = mPendA;
        eVldB    = mPendB;
        eDA      = mPendA ? mDataA : holdA;
        eDB      = mPendB ? mDataB : holdB;
        if (!rst_n) begin
            eBusy = 0; eDone = 0; eWrAck = 0; eWe = 0; eWa = 0; eWd = 0;
            eAckA = 0; eAckB = 0; eRdCe = 0; eRa = 0; eVldA = 0; eVldB = 0; eDA = 0; eDB = 0;
        end
        @(negedge clk);
        {sBusy, sDone, sWrAck, sAckA, sAckB, sVldA, sVldB, sDA, sDB} =
            {o_clr_busy, o_clr_done, o_wr_ack, o_rda_ack, o_rdb_ack, o_rda_vld, o_rdb_vld,
             o_rda_data, o_rdb_data};
        check("clr", 64'({o_clr_busy, o_clr_done}), 64'({eBusy, eDone}));
        check("wrPort", 64'({o_wr_ack, o_ram_we, o_ram_wr_ce, o_ram_wr_addr, o_ram_wr_data}),
              64'({eWrAck, eWe, eWe, eWa, eWd}));
        check("rdPort", 64'({o_rda_ack, o_rdb_ack, o_ram_rd_ce, o_ram_rd_addr}),
              64'({eAckA, eAckB, eRdCe, eRa}));
        check("retA", 64'({o_rda_vld, o_rda_data}), 64'({eVldA, eDA}));
        check("retB", 64'({o_rdb_vld, o_rdb_data}), 64'({eVldB, eDB}));
        check("noColl", 64'(o_ram_rd_ce && o_ram_we && o_ram_rd_addr == o_ram_wr_addr), 64'(0));
        if (!rst_n) begin
            mSweep = -1; mStarve = 0; mPendA = 0; mPendB = 0; holdA = 0; holdB = 0;
        end else begin
            if (mPendA) holdA = mDataA;
            if (mPendB) holdB = mDataB;
            mPendA = eAckA;
            mPendB = eAckB;
            if (eAckA) mDataA = mem[ca];
            if (eAckB) mDataB = mem[ca];
            if (eWe) mem[eWa] = eWd;
            mStarve = (!bReq || eAckB) ? 0 : candB ? mStarve : mStarve + 1;
            mSweep = idle ? (clrReq ? 0 : -1) : doneCyc ? -1 : mSweep + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int na, nb, both, cyc, busyCnt, doneCnt, doneAt, ackAt;
        logic [19:0] pat, patExp;
        rst_n = 0; initRam = 1; clrReq = 0; wrReq = 0; aReq = 0; bReq = 0;
        wrAddr = 0; wrData = 0; aAddr = 0; bAddr = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mSweep = -1; mStarve = 0; mPendA = 0; mPendB = 0; holdA = 0; holdB = 0;
        mDataA = 0; mDataB = 0;
        @(posedge clk); #1;
        initRam = 0;
        // outputs stay quiet under reset even with requests pending
        wrReq = 1; aReq = 1; aAddr = 8'h07; wrAddr = 8'h09;
        #1 check("rstQuiet", allOut(), 64'(0));
        step(); step();
        wrReq = 0; aReq = 0; rst_n = 1;
        step();

        // write then read back
        wrReq = 1; wrAddr = 8'h10; wrData = 8'hA5;
        step(); check("t1WrAck", 64'(sWrAck), 64'(1));
        wrReq = 0; aReq = 1; aAddr = 8'h10;
        step(); check("t1AckA", 64'(sAckA), 64'(1));
        aReq = 0;
        step(); check("t1Ret", 64'({sVldA, sDA}), 64'({1'b1, 8'hA5}));

        // sustained contention: B every 5th cycle
        aReq = 1; aAddr = 8'h01; bReq = 1; bAddr = 8'h02;
        na = 0; nb = 0; both = 0; pat = 0; patExp = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            na += int'(sAckA); nb += int'(sAckB); both += int'(sAckA && sAckB);
            pat[i] = sAckB; patExp[i] = (i % 5 == 4);
        end
        aReq = 0; bReq = 0;
        check("t2CntA", 64'(na), 64'(16));
        check("t2CntB", 64'(nb), 64'(4));
        check("t2Both", 64'(both), 64'(0));
        check("t2Pattern", 64'(pat), 64'(patExp));
        step();

        // clear sweep with a host write queued behind it
        clrReq = 1; wrReq = 1; wrAddr = 8'h20; wrData = 8'h5C;
        cyc = 0; busyCnt = 0; doneCnt = 0; doneAt = -1; ackAt = -1;
        while (ackAt < 0 && cyc < 400) begin
            step();
            clrReq = 0;
            busyCnt += int'(sBusy);
            if (sDone) begin doneCnt++; doneAt = cyc; end
            if (sWrAck) ackAt = cyc;
            cyc++;
        end
        wrReq = 0;
        check("t3Busy", 64'(busyCnt), 64'(256));
        check("t3DoneCnt", 64'(doneCnt), 64'(1));
        check("t3DoneAt", 64'(doneAt), 64'(257));
        check("t3AckAt", 64'(ackAt), 64'(258));
        aReq = 1; aAddr = 8'h20; bReq = 1; bAddr = 8'h21;
        step(); check("t3AckA", 64'(sAckA), 64'(1));
        aReq = 0;
        step(); check("t3RetA", 64'({sVldA, sDA, sAckB}), 64'({1'b1, 8'h5C, 1'b1}));
        bReq = 0;
        step(); check("t3RetB", 64'({sVldB, sDB}), 64'({1'b1, 8'h00}));

        // same-cycle write/read collision
        wrReq = 1; wrAddr = 8'h40; wrData = 8'h33; aReq = 1; aAddr = 8'h40;
        step(); check("t4Stall", 64'({sWrAck, sAckA}), 64'({1'b1, 1'b0}));
        wrReq = 0;
        step(); check("t4AckA", 64'(sAckA), 64'(1));
        aReq = 0;
        step(); check("t4Ret", 64'({sVldA, sDA}), 64'({1'b1, 8'h33}));

        // reset mid-sweep with a read in flight
        clrReq = 1; step(); clrReq = 0;
        repeat (99) step();
        aReq = 1; aAddr = 8'hF0;
        step();
        aReq = 0; wrReq = 1; wrAddr = 8'h05; rst_n = 0;
        #1 check("t5AsyncRst", allOut(), 64'(0));
        step(); step();
        wrReq = 0; rst_n = 1;
        doneCnt = 0;
        repeat (300) begin step(); doneCnt += int'(sDone); end
        check("t5NoDone", 64'(doneCnt), 64'(0));
        clrReq = 1; busyCnt = 0; doneCnt = 0;
        repeat (270) begin
            step(); clrReq = 0;
            busyCnt += int'(sBusy); doneCnt += int'(sDone);
        end
        check("t5Busy", 64'(busyCnt), 64'(256));
        check("t5DoneCnt", 64'(doneCnt), 64'(1));

        // a second clear request mid-sweep is ignored
        clrReq = 1; doneCnt = 0; doneAt = -1;
        for (int c = 0; c < 300; c++) begin
            clrReq = (c == 0 || c == 51);
            step();
            if (sDone) begin doneCnt++; doneAt = c; end
        end
        clrReq = 0;
        check("t6DoneCnt", 64'(doneCnt), 64'(1));
        check("t6DoneAt", 64'(doneAt), 64'(257));

        // random traffic over a narrow address range to provoke collisions
        for (int c = 0; c < 3000; c++) begin
            clrReq = ($urandom_range(0, 299) == 0);
            if (!wrReq && $urandom_range(0, 2) == 0) begin
                wrReq = 1; wrAddr = 8'($urandom_range(0, 15)); wrData = 8'($urandom);
            end
            if (!aReq && $urandom_range(0, 1) == 0) begin
                aReq = 1; aAddr = 8'($urandom_range(0, 15));
            end
            if (!bReq && $urandom_range(0, 2) != 0) begin
                bReq = 1; bAddr = 8'($urandom_range(0, 15));
            end
            step();
            if (eWrAck) wrReq = 0;
            if (eAckA) aReq = 0;
            if (eAckB) bReq = 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end
endmodule
